pll_lock_monitor: RTL and testbench

//  Multi-channel PLL lock supervisor for the HDMI/FFT clocking tree (pll_fft_256 and siblings).

---
 rtl/pll_lock_monitor.sv | 183 ++++++++++++++++++
 tb/tb_pll_lock_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_monitor.sv
// Multi-channel PLL lock supervisor: 2-flop sync, stability qualification, loss/timeout tracking.
// Optional auto-retry of a timed-out PLL is enabled with `define PLL_MON_AUTORETRY_EN.

module pll_mon_ch #(
  parameter int QUAL_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int RST_PULSE      = 16,
  parameter int CNT_W          = 3,
  parameter int CW             = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  input  logic             clr_err,
  output logic             pll_rst_o,
  output logic             lock_ok,
  output logic             err_sticky,
  output logic             timeout_flag,
  output logic [CNT_W-1:0] loss_cnt
);

`ifdef PLL_MON_AUTORETRY_EN
  typedef enum logic [1:0] {WAIT_LOCK, QUALIFY, LOCKED, RST_HOLD} st_e;
`else
  typedef enum logic [1:0] {WAIT_LOCK, QUALIFY, LOCKED} st_e;
`endif

  st_e           state, st_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    sync_q;
  logic          lock_s;
  logic          loss_evt, to_evt;

  assign lock_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      state  <= WAIT_LOCK;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_lock};
      state  <= st_d;
      cnt    <= cnt_d;
    end
  end

  always_comb begin
    st_d     = state;
    cnt_d    = cnt;
    loss_evt = 1'b0;
    to_evt   = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          st_d  = QUALIFY;
          cnt_d = '0;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          to_evt = 1'b1;
`ifdef PLL_MON_AUTORETRY_EN
          st_d   = RST_HOLD;
          cnt_d  = '0;
`else
          // park one past the threshold so the timeout fires exactly once
          cnt_d  = CW'(TIMEOUT_CYCLES);
`endif
        end else if (cnt != CW'(TIMEOUT_CYCLES)) begin
          cnt_d = cnt + CW'(1);
        end
      end
      QUALIFY: begin
        if (!lock_s) begin
          st_d  = WAIT_LOCK;
          cnt_d = '0;
        end else if (cnt == CW'(QUAL_CYCLES - 1)) begin
          st_d  = LOCKED;
          cnt_d = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      LOCKED: begin
        if (!lock_s) begin
          st_d     = WAIT_LOCK;
          cnt_d    = '0;
          loss_evt = 1'b1;
        end
      end
`ifdef PLL_MON_AUTORETRY_EN
      RST_HOLD: begin
        if (cnt == CW'(RST_PULSE - 1)) begin
          st_d  = WAIT_LOCK;
          cnt_d = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
`endif
      default: begin
        st_d  = WAIT_LOCK;
        cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    lock_ok   = (state == LOCKED);
    pll_rst_o = 1'b0;
`ifdef PLL_MON_AUTORETRY_EN
    pll_rst_o = (state == RST_HOLD);
`endif
  end

  // a coincident event beats clr_err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt     <= '0;
      err_sticky   <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      if (loss_evt) begin
        loss_cnt   <= clr_err ? CNT_W'(1) : ((&loss_cnt) ? loss_cnt : loss_cnt + CNT_W'(1));
        err_sticky <= 1'b1;
      end else if (clr_err) begin
        loss_cnt   <= '0;
        err_sticky <= 1'b0;
      end
      if (to_evt)       timeout_flag <= 1'b1;
      else if (clr_err) timeout_flag <= 1'b0;
    end
  end

endmodule

module pll_lock_monitor #(
  parameter int CH_NUM         = 2,
  parameter int QUAL_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int RST_PULSE      = 16,
  parameter int CNT_W          = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH_NUM-1:0]       pll_lock,
  input  logic                    clr_err,
  output logic [CH_NUM-1:0]       pll_rst_o,
  output logic [CH_NUM-1:0]       lock_ok,
  output logic                    all_locked,
  output logic [CH_NUM-1:0]       err_sticky,
  output logic [CH_NUM-1:0]       timeout_flag,
  output logic [CH_NUM*CNT_W-1:0] loss_cnt
);

  localparam int MAX_QT = (QUAL_CYCLES > TIMEOUT_CYCLES) ? QUAL_CYCLES : TIMEOUT_CYCLES;
  localparam int MAXC   = (MAX_QT > RST_PULSE) ? MAX_QT : RST_PULSE;
  localparam int CW     = $clog2(MAXC + 1);

  logic [CH_NUM-1:0][CNT_W-1:0] loss_cnt_ch;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    pll_mon_ch #(
      .QUAL_CYCLES   (QUAL_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .RST_PULSE     (RST_PULSE),
      .CNT_W         (CNT_W),
      .CW            (CW)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .pll_lock    (pll_lock[i]),
      .clr_err     (clr_err),
      .pll_rst_o   (pll_rst_o[i]),
      .lock_ok     (lock_ok[i]),
      .err_sticky  (err_sticky[i]),
      .timeout_flag(timeout_flag[i]),
      .loss_cnt    (loss_cnt_ch[i])
    );
  end

  assign loss_cnt   = loss_cnt_ch;
  assign all_locked = &lock_ok;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: run-length behavioural model checked every cycle, plus directed literals.
module tb_pll_lock_monitor;
  localparam int CH = 2, Q = 8, T = 32, R = 4, CW_L = 3;

  logic            clk_tb = 1'b0;
  logic            rst;
  logic [CH-1:0]   pll_lock;
  logic            clr_err;
  logic [CH-1:0]   pll_rst_o, lock_ok, err_sticky, timeout_flag;
  logic            all_locked;
  logic [CH*CW_L-1:0] loss_cnt;

  int n_vec = 0, n_err = 0;

  pll_lock_monitor #(
    .CH_NUM(CH), .QUAL_CYCLES(Q), .TIMEOUT_CYCLES(T), .RST_PULSE(R), .CNT_W(CW_L)
  ) dut (
    .clk(clk_tb), .rst(rst), .pll_lock(pll_lock), .clr_err(clr_err),
    .pll_rst_o(pll_rst_o), .lock_ok(lock_ok), .all_locked(all_locked),
    .err_sticky(err_sticky), .timeout_flag(timeout_flag), .loss_cnt(loss_cnt)
  );

  always #5 clk_tb = ~clk_tb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: lock_ok once lock_s has been high on Q+1 consecutive edges; timeout on the
  // T-th low edge counted from the edge that entered waiting.
  int         run [CH];
  int         zc  [CH];
  int         h   [CH];
  bit         s1  [CH], s2 [CH];
  bit         m_ok[CH], m_err[CH], m_to[CH];
  logic [2:0] m_cnt[CH];

  always @(posedge clk_tb or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        run[c] = 0; zc[c] = 0; h[c] = 0; s1[c] = 0; s2[c] = 0;
        m_ok[c] = 0; m_err[c] = 0; m_to[c] = 0; m_cnt[c] = 3'd0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        bit dec, loss, toe;
        dec = s2[c]; s2[c] = s1[c]; s1[c] = pll_lock[c];
        loss = 0; toe = 0;
        if (h[c] > 0) begin
          h[c]--; run[c] = 0;
          if (h[c] == 0) zc[c] = 0;
        end else if (dec) begin
          if (run[c] < Q + 1) run[c]++;
          zc[c] = -1;
        end else begin
          if (m_ok[c]) loss = 1;
          run[c] = 0;
          zc[c]++;
          if (zc[c] == T) begin
            toe = 1;
`ifdef PLL_MON_AUTORETRY_EN
            h[c] = R;
`endif
          end
        end
        m_ok[c] = (h[c] == 0) && (run[c] >= Q + 1);
        if (loss) begin
          m_cnt[c] = clr_err ? 3'd1 : ((m_cnt[c] == 3'd7) ? 3'd7 : m_cnt[c] + 3'd1);
          m_err[c] = 1;
        end else if (clr_err) begin
          m_cnt[c] = 3'd0; m_err[c] = 0;
        end
        if (toe) m_to[c] = 1;
        else if (clr_err) m_to[c] = 0;
      end
    end
  end

  always @(posedge clk_tb) begin
    #1;
    chk("cyc_lock_ok",   32'(lock_ok),      32'({m_ok[1], m_ok[0]}));
    chk("cyc_all_lock",  32'(all_locked),   32'(m_ok[1] & m_ok[0]));
    chk("cyc_err",       32'(err_sticky),   32'({m_err[1], m_err[0]}));
    chk("cyc_timeout",   32'(timeout_flag), 32'({m_to[1], m_to[0]}));
    chk("cyc_loss_cnt",  32'(loss_cnt),     32'({m_cnt[1], m_cnt[0]}));
    chk("cyc_pll_rst",   32'(pll_rst_o),    32'({h[1] > 0, h[0] > 0}));
  end

  task automatic at_edges(input int n);
    repeat (n) @(posedge clk_tb);
    #1;
  endtask

  task automatic lose0();
    @(negedge clk_tb) pll_lock[0] = 1'b0;
    @(negedge clk_tb) pll_lock[0] = 1'b1;
    repeat (12) @(negedge clk_tb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset then steady lock on both channels
    rst = 1'b1; pll_lock = 2'b11; clr_err = 1'b0;
    repeat (5) @(negedge clk_tb);
    chk("rst_lock_ok", 32'(lock_ok), 0);
    chk("rst_loss", 32'(loss_cnt), 0);
    chk("rst_pll_rst", 32'(pll_rst_o), 0);
    rst = 1'b0;
    at_edges(10); chk("t1_ok_e10", 32'(lock_ok), 0);
    at_edges(1);  chk("t1_ok_e11", 32'(lock_ok), 3);
    chk("t1_all", 32'(all_locked), 1);
    chk("t1_err", 32'(err_sticky), 0);
    chk("t1_to", 32'(timeout_flag), 0);

    // 2: one-cycle drop on ch0 while locked
    @(negedge clk_tb) pll_lock[0] = 1'b0;
    @(negedge clk_tb) pll_lock[0] = 1'b1;
    at_edges(1); chk("t2_ok_e2", 32'(lock_ok[0]), 1);
    at_edges(1); chk("t2_ok_e3", 32'(lock_ok[0]), 0);
    chk("t2_loss0", 32'(loss_cnt[2:0]), 1);
    chk("t2_err0", 32'(err_sticky[0]), 1);
    at_edges(8); chk("t2_relock_e10", 32'(lock_ok[0]), 0);
    at_edges(1); chk("t2_relock_e11", 32'(lock_ok[0]), 1);

    // 3: ch1 glitch during qualification
    @(negedge clk_tb) rst = 1'b1;
    @(negedge clk_tb) rst = 1'b0;
    at_edges(6);
    @(negedge clk_tb) pll_lock[1] = 1'b0;
    @(negedge clk_tb) pll_lock[1] = 1'b1;
    at_edges(4); chk("t3_ok_e11", 32'(lock_ok), 2'b01);
    at_edges(6); chk("t3_ok_e17", 32'(lock_ok), 2'b01);
    at_edges(1); chk("t3_ok_e18", 32'(lock_ok), 2'b11);
    chk("t3_loss1", 32'(loss_cnt[5:3]), 0);
    chk("t3_err1", 32'(err_sticky[1]), 0);

    // 4: saturation, clear, clear coincident with a loss
    for (int i = 0; i < 9; i++) lose0();
    chk("t4_sat", 32'(loss_cnt[2:0]), 7);
    chk("t4_err0", 32'(err_sticky[0]), 1);
    @(negedge clk_tb) clr_err = 1'b1;
    @(negedge clk_tb) clr_err = 1'b0;
    chk("t4_clr_loss", 32'(loss_cnt), 0);
    chk("t4_clr_err", 32'(err_sticky), 0);
    @(negedge clk_tb) pll_lock[0] = 1'b0;
    @(negedge clk_tb) pll_lock[0] = 1'b1;
    @(negedge clk_tb) clr_err = 1'b1;
    @(negedge clk_tb) clr_err = 1'b0;
    chk("t4_coinc_loss", 32'(loss_cnt[2:0]), 1);
    chk("t4_coinc_err", 32'(err_sticky[0]), 1);
    repeat (12) @(negedge clk_tb);

    // 5: ch1 never relocks
    @(negedge clk_tb) pll_lock[1] = 1'b0;
    at_edges(34); chk("t5_to_e33", 32'(timeout_flag[1]), 0);
    at_edges(1);  chk("t5_to_e34", 32'(timeout_flag[1]), 1);
    chk("t5_loss1", 32'(loss_cnt[5:3]), 1);
`ifdef PLL_MON_AUTORETRY_EN
    chk("t5_rst_on", 32'(pll_rst_o), 2'b10);
    at_edges(3);  chk("t5_rst_e37", 32'(pll_rst_o), 2'b10);
    at_edges(1);  chk("t5_rst_e38", 32'(pll_rst_o), 2'b00);
    at_edges(32); chk("t5_rst_e70", 32'(pll_rst_o), 2'b10);
    begin
      int k;
      k = 0;
      while (pll_rst_o[1] !== 1'b1 && k < 100) begin at_edges(1); k++; end
      if (k >= 100) chk("t6_wait_hold", 32'(pll_rst_o[1]), 1);
    end
    #2;
`else
    chk("t5_rst_off", 32'(pll_rst_o), 0);
    at_edges(40);
    chk("t5_rst_off2", 32'(pll_rst_o), 0);
    chk("t5_to_held", 32'(timeout_flag[1]), 1);
    @(negedge clk_tb);
`endif

    // 6: asynchronous reset mid-operation
    rst = 1'b1;
    #1;
    chk("t6_rst_pll", 32'(pll_rst_o), 0);
    chk("t6_rst_ok", 32'(lock_ok), 0);
    chk("t6_rst_to", 32'(timeout_flag), 0);
    chk("t6_rst_loss", 32'(loss_cnt), 0);
    @(negedge clk_tb) pll_lock = 2'b11;
    @(negedge clk_tb) rst = 1'b0;
    at_edges(10); chk("t6_ok_e10", 32'(lock_ok), 0);
    at_edges(1);  chk("t6_ok_e11", 32'(lock_ok), 3);
    chk("t6_all", 32'(all_locked), 1);

    @(negedge clk_tb);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
